alu_acc_seq: RTL and testbench
==============================

// Module: alu_acc_seq
// PURPOSE
//  Parametrised accumulator ALU: DATA_W-bit operand vs low DATA_W bits of a 2*DATA_W accumulator.
//  Adds SUB, a carry/borrow flag, and a multi-cycle shift-add MUL with start/busy/done handshake.
//  Sits between switch/key input logic and hex/LED display decoders; acc drives the hex digits.
// PARAMETERS
//  DATA_W   4   operand width; accumulator/result width ACC_W = 2*DATA_W (localparam)
// PORTS
//  clk      in   1        rising-edge clock, single clock domain
//  reset    in   1        synchronous, active-high; clears all state
//  en       in   1        issue op; sampled only when busy=0
//  op       in   3        operation select (table below)
//  data     in   DATA_W   operand A
//  alu_out  out  ACC_W    combinational preview of result (see BEHAVIOUR)
//  acc      out  ACC_W    accumulator register; B = acc[DATA_W-1:0]
//  flag     out  1        carry (ADD) / borrow (SUB), latched with acc
//  busy     out  1        high while MUL in progress
//  done     out  1        one-cycle pulse after acc is written
// BEHAVIOUR
//  Reset (sync, active-high): acc=0, flag=0, busy=0, done=0, MUL counter/partial=0, state=IDLE.
//  Op table (A=data, B=acc[DATA_W-1:0], results zero-extended to ACC_W):
//   000 ADD   A+B; bit DATA_W = carry; flag = carry
//   001 SUB   A-B mod 2^ACC_W (two's complement); flag = borrow (A<B)
//   010 LOGIC {~(A&B), A~^B}
//   011 ANY   (A!=0 || B!=0) ? low DATA_W bits all 1 : 0
//   100 PAT   (A one-hot && popcount(B)==2) ? high DATA_W bits all 1 : 0
//   101 CAT   {A, ~B}
//   110 HOLD  acc unchanged
//   111 MUL   A*B unsigned, shift-add, DATA_W cycles
//  flag is written only by ADD/SUB; cleared by every other completed op.
//  States: IDLE, MUL.
//   IDLE, en=1, op!=111: acc<=result at that edge; done=1 next cycle only; stay IDLE.
//   IDLE, en=1, op=111: latch A,B; partial<=0; cnt<=0; busy=1 from next cycle; go MUL.
//   MUL: each cycle, if A[cnt] add B<<cnt to partial; cnt++.
//    After DATA_W MUL cycles: acc<=partial, busy=0, done=1 for 1 cycle, go IDLE.
//   MUL latency: en edge to acc update = DATA_W+1 edges; done pulses the cycle after.
//  en while busy=1 is ignored (no queueing); op/data changes during MUL have no effect.
//  done never asserts together with busy; back-to-back single-cycle ops give done every cycle.
//  alu_out: busy=1 -> partial product; else op 000-110 -> combinational result; op 111 -> 0.
//  reset during MUL aborts: acc=0, busy=0, done stays 0 (no completion pulse).
//  All arithmetic unsigned, wraps mod 2^ACC_W; no saturation.
// TESTING (DATA_W=4)
//  reset, en ADD data=9 -> acc=0x09, flag=0, done=1 one cycle; ADD 9 again -> acc=0x12, flag=1
//  acc=0x05, SUB data=2 -> acc=0xFD, flag=1; then HOLD -> acc=0xFD, flag=0
//  acc=0x03, LOGIC data=0xA -> acc=0xD6; acc=0x06, PAT data=0x4 -> 0xF0; PAT data=0x3 -> 0x00
//  acc=0x05, MUL data=3 -> busy 4 cycles, acc=0x0F, done 1 cycle; en ADD during busy ignored
//  acc=0x0F, MUL data=0xF -> acc=0xE1 after 4 cycles; alu_out tracks partial while busy
//  start MUL, assert reset at cycle 2 -> acc=0, busy=0, no done; next ADD data=1 -> acc=0x01

Source files
------------

// File: rtl/alu_acc_seq.sv
// Accumulator ALU: DATA_W-bit operand against the low half of a 2*DATA_W accumulator,
// with single-cycle ops and a DATA_W-cycle shift-add multiply behind a busy/done handshake.
module alu_acc_seq #(
   parameter int unsigned DATA_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [2:0]            op,
   input  logic [DATA_W-1:0]     data,
   output logic [2*DATA_W-1:0]   alu_out,
   output logic [2*DATA_W-1:0]   acc,
   output logic                  flag,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned ACC_W = 2 * DATA_W;
   localparam int unsigned CntW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

   localparam logic [2:0] OpAdd   = 3'b000;
   localparam logic [2:0] OpSub   = 3'b001;
   localparam logic [2:0] OpLogic = 3'b010;
   localparam logic [2:0] OpAny   = 3'b011;
   localparam logic [2:0] OpPat   = 3'b100;
   localparam logic [2:0] OpCat   = 3'b101;
   localparam logic [2:0] OpHold  = 3'b110;
   localparam logic [2:0] OpMul   = 3'b111;

   typedef enum logic {StIdle, StMul} state_e;

   state_e              state_q, state_d;
   logic [ACC_W-1:0]    acc_q;
   logic                flag_q;
   logic                done_q;
   logic [ACC_W-1:0]    partial_q;
   logic [DATA_W-1:0]   mul_a_q;
   logic [DATA_W-1:0]   mul_b_q;
   logic [CntW-1:0]     cnt_q;

   logic [DATA_W-1:0]   b;
   logic [DATA_W:0]     sum;
   logic [ACC_W-1:0]    res;
   logic                res_flag;
   logic [ACC_W-1:0]    partial_nxt;
   logic                issue_single;
   logic                issue_mul;
   logic                mul_step;
   logic                mul_last;

   assign b = acc_q[DATA_W-1:0];

   // Result of the single-cycle ops, also used as the alu_out preview.
   always_comb begin
      sum      = '0;
      res      = '0;
      res_flag = 1'b0;
      case (op)
         OpAdd: begin
            sum      = {1'b0, data} + {1'b0, b};
            res      = ACC_W'(sum);
            res_flag = sum[DATA_W];
         end
         OpSub: begin
            res      = {{DATA_W{1'b0}}, data} - {{DATA_W{1'b0}}, b};
            res_flag = (data < b);
         end
         OpLogic: res = {~(data & b), data ~^ b};
         OpAny:   res = ((data != '0) || (b != '0)) ? {{DATA_W{1'b0}}, {DATA_W{1'b1}}} : '0;
         OpPat: begin
            if ((data != '0) && ((data & (data - 1'b1)) == '0) && ($countones(b) == 2)) begin
               res = {{DATA_W{1'b1}}, {DATA_W{1'b0}}};
            end
         end
         OpCat:   res = {data, ~b};
         OpHold:  res = acc_q;
         default: res = '0;
      endcase
   end

   always_comb begin
      partial_nxt = partial_q;
      if (mul_a_q[cnt_q]) begin
         partial_nxt = partial_q + ({{DATA_W{1'b0}}, mul_b_q} << cnt_q);
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (en && (op == OpMul)) state_d = StMul;
         StMul:   if (cnt_q == CntLast) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs and datapath strobes
   always_comb begin
      busy         = (state_q == StMul);
      issue_single = (state_q == StIdle) && en && (op != OpMul);
      issue_mul    = (state_q == StIdle) && en && (op == OpMul);
      mul_step     = (state_q == StMul);
      mul_last     = (state_q == StMul) && (cnt_q == CntLast);
      if (busy) begin
         alu_out = partial_q;
      end else if (op == OpMul) begin
         alu_out = '0;
      end else begin
         alu_out = res;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q     <= '0;
         flag_q    <= 1'b0;
         done_q    <= 1'b0;
         partial_q <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         cnt_q     <= '0;
      end else begin
         done_q <= 1'b0;
         if (issue_single) begin
            acc_q  <= res;
            flag_q <= res_flag;
            done_q <= 1'b1;
         end
         if (issue_mul) begin
            mul_a_q   <= data;
            mul_b_q   <= b;
            partial_q <= '0;
            cnt_q     <= '0;
         end
         if (mul_step) begin
            partial_q <= partial_nxt;
            cnt_q     <= cnt_q + 1'b1;
            // Final step writes the completed product straight into acc.
            if (mul_last) begin
               acc_q  <= partial_nxt;
               flag_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign acc  = acc_q;
   assign flag = flag_q;
   assign done = done_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq with DATA_W=4; inputs driven and outputs sampled on negedge.
module tb_alu_acc_seq;

   localparam logic [2:0] OpAdd   = 3'b000;
   localparam logic [2:0] OpSub   = 3'b001;
   localparam logic [2:0] OpLogic = 3'b010;
   localparam logic [2:0] OpAny   = 3'b011;
   localparam logic [2:0] OpPat   = 3'b100;
   localparam logic [2:0] OpCat   = 3'b101;
   localparam logic [2:0] OpHold  = 3'b110;
   localparam logic [2:0] OpMul   = 3'b111;

   logic       clk;
   logic       reset;
   logic       en;
   logic [2:0] op;
   logic [3:0] data;
   logic [7:0] alu_out;
   logic [7:0] acc;
   logic       flag;
   logic       busy;
   logic       done;

   int checks;
   int failures;

   alu_acc_seq #(.DATA_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .op      (op),
      .data    (data),
      .alu_out (alu_out),
      .acc     (acc),
      .flag    (flag),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      en    = 1'b0;
      op    = OpHold;
      data  = 4'h0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Issue one op for a single cycle; returns at the negedge where the result is visible.
   task automatic op_once(input logic [2:0] o, input logic [3:0] d);
      @(negedge clk);
      en   = 1'b1;
      op   = o;
      data = d;
      @(negedge clk);
      en   = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      en    = 1'b0;
      op    = OpHold;
      data  = 4'h0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (acc !== 8'h00 || flag !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got acc=%h flag=%b busy=%b done=%b exp 00/0/0/0",
                  acc, flag, busy, done);
      end
      checks++;
      if (alu_out !== 8'h00) begin
         failures++;
         $display("FAIL reset_alu_out got=%h exp=00", alu_out);
      end
      reset = 1'b0;
   endtask

   task automatic test_add();
      do_reset();
      op_once(OpAdd, 4'h9);
      checks++;
      if (acc !== 8'h09 || flag !== 1'b0 || done !== 1'b1) begin
         failures++;
         $display("FAIL add1 got acc=%h flag=%b done=%b exp 09/0/1", acc, flag, done);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL add1_done_pulse got=%b exp=0", done);
      end
      op_once(OpAdd, 4'h9);
      checks++;
      if (acc !== 8'h12 || flag !== 1'b1) begin
         failures++;
         $display("FAIL add2_carry got acc=%h flag=%b exp 12/1", acc, flag);
      end
   endtask

   task automatic test_sub_hold();
      do_reset();
      op_once(OpAdd, 4'h5);
      op_once(OpSub, 4'h2);
      checks++;
      if (acc !== 8'hFD || flag !== 1'b1) begin
         failures++;
         $display("FAIL sub_borrow got acc=%h flag=%b exp FD/1", acc, flag);
      end
      op_once(OpHold, 4'h7);
      checks++;
      if (acc !== 8'hFD || flag !== 1'b0 || done !== 1'b1) begin
         failures++;
         $display("FAIL hold got acc=%h flag=%b done=%b exp FD/0/1", acc, flag, done);
      end
   endtask

   task automatic test_logic();
      do_reset();
      op_once(OpAdd, 4'h3);
      @(negedge clk);
      op   = OpLogic;
      data = 4'hA;
      #1;
      checks++;
      if (alu_out !== 8'hD6) begin
         failures++;
         $display("FAIL logic_preview got=%h exp=D6", alu_out);
      end
      op_once(OpLogic, 4'hA);
      checks++;
      if (acc !== 8'hD6) begin
         failures++;
         $display("FAIL logic got=%h exp=D6", acc);
      end
   endtask

   task automatic test_pat();
      do_reset();
      op_once(OpAdd, 4'h6);
      op_once(OpPat, 4'h4);
      checks++;
      if (acc !== 8'hF0) begin
         failures++;
         $display("FAIL pat_hit got=%h exp=F0", acc);
      end
      op_once(OpPat, 4'h3);
      checks++;
      if (acc !== 8'h00) begin
         failures++;
         $display("FAIL pat_after got=%h exp=00", acc);
      end
      do_reset();
      op_once(OpAdd, 4'h6);
      op_once(OpPat, 4'h3);
      checks++;
      if (acc !== 8'h00) begin
         failures++;
         $display("FAIL pat_not_onehot got=%h exp=00", acc);
      end
      do_reset();
      op_once(OpAdd, 4'h7);
      op_once(OpPat, 4'h4);
      checks++;
      if (acc !== 8'h00) begin
         failures++;
         $display("FAIL pat_pop3 got=%h exp=00", acc);
      end
   endtask

   task automatic test_any_cat();
      do_reset();
      op_once(OpAny, 4'h0);
      checks++;
      if (acc !== 8'h00) begin
         failures++;
         $display("FAIL any_zero got=%h exp=00", acc);
      end
      op_once(OpAny, 4'h2);
      checks++;
      if (acc !== 8'h0F) begin
         failures++;
         $display("FAIL any_a got=%h exp=0F", acc);
      end
      op_once(OpAny, 4'h0);
      checks++;
      if (acc !== 8'h0F) begin
         failures++;
         $display("FAIL any_b got=%h exp=0F", acc);
      end
      op_once(OpCat, 4'h9);
      checks++;
      if (acc !== 8'h90) begin
         failures++;
         $display("FAIL cat1 got=%h exp=90", acc);
      end
      op_once(OpCat, 4'h3);
      checks++;
      if (acc !== 8'h3F) begin
         failures++;
         $display("FAIL cat2 got=%h exp=3F", acc);
      end
   endtask

   task automatic test_mul_basic();
      int n;
      do_reset();
      op_once(OpAdd, 4'h5);
      en   = 1'b1;
      op   = OpMul;
      data = 4'h3;
      @(negedge clk);
      // A new op during busy must be dropped.
      op   = OpAdd;
      data = 4'h1;
      n    = 0;
      while (busy === 1'b1 && n < 20) begin
         n++;
         checks++;
         if (done !== 1'b0) begin
            failures++;
            $display("FAIL mul_done_with_busy got=%b exp=0", done);
         end
         @(negedge clk);
      end
      en = 1'b0;
      checks++;
      if (n != 4) begin
         failures++;
         $display("FAIL mul_busy_cycles got=%0d exp=4", n);
      end
      checks++;
      if (acc !== 8'h0F || done !== 1'b1 || busy !== 1'b0 || flag !== 1'b0) begin
         failures++;
         $display("FAIL mul_5x3 got acc=%h done=%b busy=%b flag=%b exp 0F/1/0/0",
                  acc, done, busy, flag);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || acc !== 8'h0F) begin
         failures++;
         $display("FAIL mul_after got done=%b acc=%h exp 0/0F", done, acc);
      end
   endtask

   task automatic test_mul_partial();
      logic [7:0] exp_p [4];
      exp_p[0] = 8'h00;
      exp_p[1] = 8'h0F;
      exp_p[2] = 8'h2D;
      exp_p[3] = 8'h69;
      do_reset();
      op_once(OpAdd, 4'hF);
      en   = 1'b1;
      op   = OpMul;
      data = 4'hF;
      @(negedge clk);
      en   = 1'b0;
      op   = OpLogic;
      data = 4'h0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (busy !== 1'b1 || alu_out !== exp_p[i]) begin
            failures++;
            $display("FAIL mul_partial%0d got busy=%b alu_out=%h exp 1/%h",
                     i, busy, alu_out, exp_p[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (acc !== 8'hE1 || busy !== 1'b0 || done !== 1'b1) begin
         failures++;
         $display("FAIL mul_FxF got acc=%h busy=%b done=%b exp E1/0/1", acc, busy, done);
      end
   endtask

   task automatic test_mul_flag();
      do_reset();
      op_once(OpAdd, 4'h9);
      op_once(OpAdd, 4'h9);
      op_once(OpMul, 4'h3);
      for (int i = 0; i < 4; i++) @(negedge clk);
      checks++;
      if (acc !== 8'h06 || flag !== 1'b0 || done !== 1'b1) begin
         failures++;
         $display("FAIL mul_clears_flag got acc=%h flag=%b done=%b exp 06/0/1",
                  acc, flag, done);
      end
   endtask

   task automatic test_mul_reset();
      do_reset();
      op_once(OpAdd, 4'hF);
      en   = 1'b1;
      op   = OpMul;
      data = 4'hF;
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (acc !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL mul_abort got acc=%h busy=%b done=%b exp 00/0/0", acc, busy, done);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mul_abort_quiet%0d got done=%b busy=%b exp 0/0", i, done, busy);
         end
      end
      op_once(OpAdd, 4'h1);
      checks++;
      if (acc !== 8'h01 || done !== 1'b1) begin
         failures++;
         $display("FAIL mul_abort_add got acc=%h done=%b exp 01/1", acc, done);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      @(negedge clk);
      en   = 1'b1;
      op   = OpAdd;
      data = 4'h1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b1 || acc !== 8'(i + 1)) begin
            failures++;
            $display("FAIL b2b%0d got done=%b acc=%h exp 1/%h", i, done, acc, 8'(i + 1));
         end
      end
      en = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || acc !== 8'h04) begin
         failures++;
         $display("FAIL b2b_end got done=%b acc=%h exp 0/04", done, acc);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      en       = 1'b0;
      op       = OpHold;
      data     = 4'h0;
      test_reset();
      test_add();
      test_sub_hold();
      test_logic();
      test_pat();
      test_any_cat();
      test_mul_basic();
      test_mul_partial();
      test_mul_flag();
      test_mul_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
